// File: rtl/pp_pkg.sv
// Shared constants, column geometry helpers and FSM state type for the
// partial-product serializer.
package pp_pkg;

   localparam int PP_N    = 12;
   localparam int PP_NCOL = 2 * PP_N - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } pp_state_e;

   // Number of partial products landing in column k of an n x n array.
   function automatic int col_height(input int k, input int n);
      int lo_side;
      lo_side = (k < 2 * n - 2 - k) ? k : 2 * n - 2 - k;
      return lo_side + 1;
   endfunction

   // Lowest multiplicand index contributing to column k.
   function automatic int col_ilo(input int k, input int n);
      return (k - n + 1 > 0) ? k - n + 1 : 0;
   endfunction

endpackage

// File: rtl/pp_column_mux.sv
// Per-column selector: picks the partial product that column K must receive
// during push t (tallest element first, element 0 last).
module pp_column_mux
   import pp_pkg::*;
#(
   parameter int N  = PP_N,
   parameter int K  = 0,
   parameter int TW = $clog2(PP_N)
) (
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic [TW-1:0] t,
   input  logic          active,
   output logic          ser
);

   localparam int H   = col_height(K, N);
   localparam int ILO = col_ilo(K, N);
   localparam int W2  = 2 * N;
   // b is reversed and slid so that bit i lines up with b[K-i] under a[i].
   localparam int SR  = (K <= N - 1) ? N - 1 - K : 0;
   localparam int SL  = (K >  N - 1) ? K - N + 1 : 0;

   logic [W2-1:0] a_ext;
   logic [W2-1:0] b_rev;
   logic [W2-1:0] b_aln;
   logic [W2-1:0] sel;
   int            nsel;

   always_comb begin
      a_ext = {{N{1'b0}}, a};
      b_rev = '0;
      for (int m = 0; m < N; m++) begin
         b_rev[m] = b[N-1-m];
      end
      b_aln = (b_rev >> SR) << SL;
      nsel  = N - 1 - int'(t);
      sel   = '0;
      if (active && (nsel >= 0) && (nsel < H)) begin
         sel = {{(W2-1){1'b0}}, 1'b1} << (ILO + nsel);
      end
      ser = |(a_ext & b_aln & sel);
   end

endmodule

// File: rtl/pp_serializer.sv
// Partial-product serializer: latches one operand pair and streams every AND
// partial product into the column shift register over N pushes.
module pp_serializer
   import pp_pkg::*;
#(
   parameter int N = PP_N,
   localparam int NCOL = 2 * N - 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic [NCOL-1:0] ser,
   output logic            busy,
   output logic            frame_valid
);

   localparam int TW = (N > 1) ? $clog2(N) : 1;

   pp_state_e     state;
   logic [TW-1:0] t_q;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic          accept;

   assign in_ready    = (state != ST_SHIFT);
   assign busy        = (state == ST_SHIFT);
   assign frame_valid = (state == ST_DONE);
   assign accept      = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         t_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // DONE accepts too, so continuous traffic runs without a gap cycle.
               if (accept) begin
                  a_q   <= a;
                  b_q   <= b;
                  t_q   <= '0;
                  state <= ST_SHIFT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (t_q == TW'(N - 1)) begin
                  state <= ST_DONE;
               end else begin
                  t_q <= t_q + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // One combinational selector per column; ser depends only on registered state.
   for (genvar k = 0; k < NCOL; k++) begin : g_col
      pp_column_mux #(
         .N  (N),
         .K  (k),
         .TW (TW)
      ) u_mux (
         .a      (a_q),
         .b      (b_q),
         .t      (t_q),
         .active (busy),
         .ser    (ser[k])
      );
   end

endmodule

// File: tb/tb_pp_serializer.sv
// Scoreboard bench for pp_serializer: directed corner frames, an abort by reset,
// and 1000 random frames checked against a column-level reference.
module tb_pp_serializer;

   localparam int N    = 12;
   localparam int NCOL = 2 * N - 1;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      int           fv_edge;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N-1:0]    a = '0;
   logic [N-1:0]    b = '0;
   logic [NCOL-1:0] ser;
   logic            busy;
   logic            frame_valid;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_cnt = 0;
   int   acc_edge = -1000;
   exp_t sb[$];
   logic [N-1:0] colreg [NCOL];

   pp_serializer #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .ser         (ser),
      .busy        (busy),
      .frame_valid (frame_valid)
   );

   always #5 clk = ~clk;

   function automatic int hgt(input int k);
      return (k < 2 * N - 2 - k) ? k + 1 : 2 * N - 1 - k;
   endfunction

   function automatic logic [N-1:0] hmask(input int k);
      return N'((1 << hgt(k)) - 1);
   endfunction

   // Reference column: bit n holds a[lo+n] & b[k-lo-n], built by walking i+j=k.
   function automatic logic [N-1:0] ref_col(input logic [N-1:0] av, input logic [N-1:0] bv,
                                            input int k);
      logic [N-1:0] c;
      int lo;
      c  = '0;
      lo = (k - N + 1 > 0) ? k - N + 1 : 0;
      for (int i = 0; i < N; i++) begin
         if ((k - i >= 0) && (k - i < N)) c[i-lo] = av[i] & bv[k-i];
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_cnt, act, req);
      end
   endtask

   // Transaction model plus the downstream column shift registers fed by ser.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_edge <= -1000;
         sb.delete();
      end else begin
         edge_cnt <= edge_cnt + 1;
         for (int k = 0; k < NCOL; k++) begin
            colreg[k] <= ((colreg[k] << 1) | N'(ser[k])) & hmask(k);
         end
         if (in_valid && (edge_cnt + 1 > acc_edge + N)) begin
            acc_edge <= edge_cnt + 1;
            sb.push_back('{a: a, b: b, fv_edge: edge_cnt + 1 + N});
         end
      end
   end

   task automatic monitor_cycle();
      int e;
      bit eb;
      bit ef;
      logic [NCOL-1:0] es;
      logic [63:0] sum;
      exp_t f;
      e  = edge_cnt;
      eb = (acc_edge <= e) && (e <= acc_edge + N - 1);
      ef = (e == acc_edge + N);
      es = '0;
      if (eb && (sb.size() > 0)) begin
         for (int k = 0; k < NCOL; k++) begin
            if (N - 1 - (e - acc_edge) < hgt(k)) es[k] = ref_col(sb[0].a, sb[0].b, k)[N-1-(e-acc_edge)];
         end
      end
      chk("busy", 64'(busy), 64'(eb));
      chk("in_ready", 64'(in_ready), 64'(!eb));
      chk("frame_valid", 64'(frame_valid), 64'(ef));
      chk("ser", 64'(ser), 64'(es));
      if (frame_valid) begin
         chk("fv_pending", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            f = sb.pop_front();
            chk("fv_latency", 64'(e), 64'(f.fv_edge));
            sum = '0;
            for (int k = 0; k < NCOL; k++) begin
               chk($sformatf("col%0d", k), 64'(colreg[k]), 64'(ref_col(f.a, f.b, k)));
               for (int n = 0; n < hgt(k); n++) begin
                  if (colreg[k][n]) sum = sum + (64'(1) << k);
               end
            end
            chk("product", sum, 64'(f.a) * 64'(f.b));
         end
      end
   endtask

   always @(negedge clk) monitor_cycle();

   // Caller is always at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input bit keep_valid);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      a = av;
      b = bv;
      for (int i = 0; i < 4 * N && !accepted; i++) begin
         @(posedge clk);
         #1;
         if (acc_edge == edge_cnt) accepted = 1'b1;
      end
      chk("accept_timeout", 64'(accepted), 64'(1));
      if (!keep_valid) in_valid = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * N && sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", 64'(sb.size()), 64'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ser"}, 64'(ser), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_fv"}, 64'(frame_valid), 64'(0));
      chk({tag, "_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      #1;
      chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      send(12'hFFF, 12'hFFF, 1'b0);
      drain();
      send(12'h001, 12'h001, 1'b0);
      drain();
      send(12'h800, 12'h001, 1'b0);
      drain();

      // Held in_valid: second pair waits through SHIFT and is taken in DONE.
      send(12'hFFF, 12'hFFF, 1'b1);
      send(12'h001, 12'h001, 1'b0);
      drain();

      // Abort at push t=5, then a clean frame.
      send(N'($urandom), N'($urandom), 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("abort");
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      send(N'($urandom), N'($urandom), 1'b0);
      drain();

      for (int fr = 0; fr < 1000; fr++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0));
      end
      in_valid = 1'b0;
      drain();
      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      n_bad++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pp_serializer.md
# pp_serializer

Partial-product serializer for the 12x12 multiplier compressor harness. It accepts one operand pair per transaction and forms all N*N AND partial products. Over N clock cycles it drives one bit per column into the per-column serial inputs of the column shift register. After the last push, every column register holds exactly its partial-product bits for the compressor. The block sits directly upstream of the shift register: its ser[k] drives that register's srck_ input.

## Interface
- N, default 12: operand width. NCOL = 2N-1 columns; column k height h_k = min(k, 2N-2-k) + 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- ser  out  NCOL  serial bit per column. ser[k] connects to srck_ of the shift register.
- busy  out  1  high while a frame is being pushed.
- frame_valid  out  1  one-cycle pulse. Shift-register contents form a complete frame during this cycle.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept: in_valid && in_ready at a rising edge.
  - On accept, latch a and b, clear push counter t to 0, and enter SHIFT.
- in_ready:
  - high in IDLE and DONE.
  - low in SHIFT.
  - in_valid in SHIFT is ignored, with no latching and no error.
- SHIFT:
  - Push t, with t from 0 to N-1, is presented during one cycle.
  - t increments at each edge.
  - At the edge where t = N-1, go to DONE.
- DONE:
  - frame_valid = 1 for exactly this cycle.
  - An accept here goes to SHIFT with back-to-back frames and no gap cycle.
  - Otherwise go to IDLE.
- Column bit ordering for column k:
  - i_lo = max(0, k-N+1).
  - Element n, for n from 0 to h_k-1, = a[i_lo+n] & b[k-i_lo-n].
- Push rule: in push t, element index n = N-1-t.
  - ser[k] = element n if n < h_k, else 0.
  - Consequence: element n ends in column register bit n. Element 0, pushed last, is bit 0.
- Outside SHIFT, ser is all zeros.
- ser, busy and frame_valid are decoded from registered state only. They never depend combinationally on in_valid, a or b.

## Timing
- Reset values: state IDLE, t = 0, latched a/b = 0, ser = 0, busy = 0, frame_valid = 0, in_ready = 1.
- Reset is asynchronous and may assert mid-SHIFT.
  - The frame is abandoned and no frame_valid is issued.
  - The first accept after deassertion starts a fresh frame.
- Accept at edge E0:
  - Pushes t = 0..N-1 are presented in cycles E0..E(N-1).
  - The shift register samples them at edges E1..EN.
  - frame_valid is high in the cycle between EN and E(N+1).
  - Latency from accept edge to frame_valid is N cycles; for N = 12, that is 12.
- busy = 1 exactly in SHIFT.
- Throughput with continuous in_valid: one frame per N+1 cycles.
- If no new accept occurs in DONE, the shift register keeps shifting zeros afterwards. The frame is guaranteed valid only in the frame_valid cycle.
- Operand inputs may change freely after the accept edge.

## Structure
- Shared package pp_pkg holds:
  - N and NCOL constants.
  - Functions col_height(k) and col_ilo(k).
  - The state enum (IDLE/SHIFT/DONE).
- Sub-module pp_column_mux, one instance per column, parameterised by K.
  - Inputs: latched a, latched b, t, shift-active.
  - Output: ser[K].
  - Purely combinational; the generate loop instantiates NCOL copies.
- Top level holds the FSM, the push counter (width clog2(N)) and the operand latches.

## Test plan
- a=0xFFF, b=0xFFF, single accept:
  - In push t, ser[k]=1 iff 11-t < h_k.
  - After 12 edges every column register is all ones.
  - frame_valid is high exactly 12 cycles after accept.
- a=0x001, b=0x001:
  - ser[0]=1 only in push t=11; all other ser bits stay 0 throughout.
  - At frame_valid, src0=1 and all other columns are 0.
- a=0x800, b=0x001:
  - ser[11]=1 only in push t=0.
  - At frame_valid, src11 = 12'h800 and all other columns are 0.
- Back-to-back:
  - in_valid held high with a=0xFFF/b=0xFFF, then a=0x001/b=0x001 offered in the DONE cycle.
  - Second SHIFT starts immediately.
  - frame_valid pulses 13 cycles apart.
  - in_valid asserted during SHIFT is ignored.
- Reset at push t=5:
  - All outputs return to reset values asynchronously.
  - No frame_valid is issued.
  - A subsequent accept produces a correct full frame.
- Random operands, 1000 frames:
  - At each frame_valid, the bench's column-register model equals the reference partial-product columns.
  - The compressor's dst bus equals a*b.
